inst_mem_responder: RTL and testbench
=====================================

// Module: inst_mem_responder
// PURPOSE
//  Word-addressed instruction memory acting as the responder end of the CPU fetch interface.
//  Accepts one fetch request at a time and, after a programmable wait count, returns a
//  32-bit instruction word to the CPU on inst_Din.
//  Instruction layout: opcode[31:26] | rs1[25:22] | rs2[21:18] | rd[17:14] | imm[13:0].
//  A side-band load port preloads programs before and between fetches.
// PARAMETERS
//  ADDR_W       8   word-address width; memory depth = 2**ADDR_W words
//  WAIT_CYCLES  2   extra cycles between request capture and response (0..15)
// PORTS
//  clk          in   1       system clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  fetch_req    in   1       fetch request; sampled only in IDLE
//  fetch_addr   in   32      byte address of the instruction (PC)
//  busy         out  1       high from the capture edge until the ack cycle, inclusive
//  fetch_ack    out  1       1-cycle pulse; inst_Din/fetch_err are valid in this cycle
//  inst_Din     out  32      instruction word; holds its value until the next ack
//  fetch_err    out  1       qualified by fetch_ack: misaligned or out-of-range address
//  load_en      in   1       program-load write strobe
//  load_addr    in   ADDR_W  word address for the load
//  load_data    in   32      word written on load_en
// BEHAVIOUR
//  - Reset (async): state=IDLE, wait counter=0, busy=0, fetch_ack=0, fetch_err=0,
//    inst_Din=32'h0. Memory array is not cleared.
//  - FSM states: IDLE, WAIT, RESP, ERR.
//    IDLE: fetch_req=1 -> capture fetch_addr.
//          If fetch_addr[1:0]!=0 or fetch_addr[31:ADDR_W+2]!=0 -> ERR.
//          Else if WAIT_CYCLES==0 -> RESP.
//          Else load counter with WAIT_CYCLES-1 -> WAIT.
//    WAIT: counter==0 -> RESP; otherwise decrement.
//    RESP: fetch_ack=1, fetch_err=0, inst_Din=mem[addr[ADDR_W+1:2]] (registered on the
//          edge entering RESP) -> IDLE.
//    ERR:  fetch_ack=1, fetch_err=1, inst_Din=32'h0 (NOP) -> IDLE.
//  - Latency: req sampled at edge N gives ack high in cycle N+1+WAIT_CYCLES.
//    An error response always acks in cycle N+1.
//  - fetch_req is ignored outside IDLE; no queuing.
//    A request held high through the ack cycle is recaptured on the edge leaving RESP/ERR,
//    giving back-to-back fetches with no idle gap.
//  - fetch_ack and fetch_err are registered; they are never high for 2 consecutive cycles
//    for the same request.
//  - Load port: mem[load_addr] <= load_data on any edge with load_en=1, in any state.
//    Same-edge collision with the RESP read of the same word is read-before-write:
//    the response carries the old word, and the next fetch sees the new word.
//  - Reset mid-operation aborts the fetch: no ack is issued, and the captured address
//    is discarded.
// STRUCTURE
//  - Shared cpu package: opcode/field position constants (OPC_MSB=31, RS1_MSB=25,
//    RS2_MSB=21, RD_MSB=17, IMM_W=14), NOP_WORD=32'h0, and fetch FSM state encodings
//    (2-bit).
//  - One sub-module: inst_mem_array (single write port, single registered read port,
//    2**ADDR_W x 32).
//  - FSM, wait counter and address checks live in the top module.
// TESTING
//  1. Reset then idle: rst=1 for 2 cycles -> busy=0, fetch_ack=0, inst_Din=0;
//     no ack for 10 cycles with fetch_req=0.
//  2. Load mem[3]=32'h0297FD90, then fetch_addr=0x0C (WAIT_CYCLES=2)
//     -> ack exactly 3 cycles after capture, inst_Din=32'h0297FD90, fetch_err=0.
//  3. fetch_addr=0x0000_0006 (misaligned) and separately 0x0000_0400 (out of range,
//     ADDR_W=8) -> ack next cycle, fetch_err=1, inst_Din=0.
//  4. fetch_req held high over addresses 0x0,0x4,0x8 -> three acks spaced 3 cycles apart,
//     words returned in order. A req pulse while busy=1 produces no extra ack.
//  5. Collision: load_en to word 5 on the RESP-entry edge of a fetch of 0x14
//     -> old word returned; an immediate refetch returns the new word.
//  6. Assert rst during WAIT -> no ack; busy=0 next cycle; a subsequent fetch of 0x0C
//     completes normally.

Source files
------------

// File: rtl/inst_mem_responder_pkg.sv
// Shared CPU definitions for the instruction fetch path.
// Contents: instruction field positions, the NOP encoding, wait-counter width and
// the fetch FSM state encoding used by inst_mem_responder.
package inst_mem_responder_pkg;

  // Instruction layout: opcode | rs1 | rs2 | rd | imm
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned RS1_MSB = 25;
  localparam int unsigned RS2_MSB = 21;
  localparam int unsigned RD_MSB  = 17;
  localparam int unsigned IMM_W   = 14;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Wait counter holds WAIT_CYCLES-1, with WAIT_CYCLES limited to 0..15
  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StResp = 2'b10,
    StErr  = 2'b11
  } fetch_state_e;

  function automatic logic [5:0] inst_opcode(input logic [31:0] inst);
    return inst[OPC_MSB -: 6];
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: 2**ADDR_W x 32, one write port, one registered read port.
// Ports:
//   clk_i, rst_i        clock and async active-high reset (read register only)
//   we_i/waddr_i/wdata_i write port, any cycle
//   rd_en_i/raddr_i      load the read register from the array
//   rd_clr_i             load the read register with NOP (wins over rd_en_i)
//   rd_data_o            read register; holds until next rd_en_i/rd_clr_i
module inst_mem_array
  import inst_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic              rd_en_i,
  input  logic              rd_clr_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rd_data_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rd_data_q;

  // Array contents survive reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Same-edge write to the read word returns the old contents (read-before-write)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= NOP_WORD;
    end else if (rd_clr_i) begin
      rd_data_q <= NOP_WORD;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[raddr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction memory responder for the CPU fetch interface.
// Captures one fetch at a time, waits WAIT_CYCLES, then pulses fetch_ack with the
// instruction on inst_Din. Misaligned or out-of-range addresses ack next cycle with
// fetch_err=1 and a NOP. A side-band load port writes the array in any state.
// Ports:
//   clk, rst                   clock, async active-high reset
//   fetch_req, fetch_addr      request and byte address (PC)
//   busy                       capture edge through ack cycle
//   fetch_ack, fetch_err       registered response strobe and error flag
//   inst_Din                   instruction word, held until next ack
//   load_en, load_addr, load_data  program-load write port
module inst_mem_responder
  import inst_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              busy,
  output logic              fetch_ack,
  output logic [31:0]       inst_Din,
  output logic              fetch_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data
);

  localparam logic [WAIT_W-1:0] WaitLoad =
      (WAIT_CYCLES == 0) ? '0 : WAIT_W'(WAIT_CYCLES - 1);

  fetch_state_e      state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  logic              rd_en;
  logic              rd_clr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] req_word;
  logic              req_bad;

  assign req_word = fetch_addr[ADDR_W+1:2];
  assign req_bad  = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (ADDR_W + 2)) != 32'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rd_en   = 1'b0;
    rd_clr  = 1'b0;
    rd_addr = addr_q;

    case (state_q)
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
          ack_d   = 1'b1;
          rd_en   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // IDLE, and RESP/ERR on their way back to IDLE: a held request is recaptured
      // here so back-to-back fetches need no idle cycle.
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        if (fetch_req) begin
          busy_d = 1'b1;
          addr_d = req_word;
          if (req_bad) begin
            state_d = StErr;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            rd_clr  = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            state_d = StResp;
            ack_d   = 1'b1;
            rd_en   = 1'b1;
            rd_addr = req_word;
          end else begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  inst_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (load_en),
    .waddr_i   (load_addr),
    .wdata_i   (load_data),
    .rd_en_i   (rd_en),
    .rd_clr_i  (rd_clr),
    .raddr_i   (rd_addr),
    .rd_data_o (inst_Din)
  );

  assign busy      = busy_q;
  assign fetch_ack = ack_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
module tb_inst_mem_responder;

  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fetch_req = 1'b0;
  logic [31:0]       fetch_addr = '0;
  logic              busy;
  logic              fetch_ack;
  logic [31:0]       inst_Din;
  logic              fetch_err;
  logic              load_en = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [31:0]       load_data = '0;

  int checks = 0;
  int errors = 0;

  inst_mem_responder #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .busy       (busy),
    .fetch_ack  (fetch_ack),
    .inst_Din   (inst_Din),
    .fetch_err  (fetch_err),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Count acks over n cycles; expect none
  task automatic expect_quiet(input string tag, input int n);
    int acks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (fetch_ack) acks++;
    end
    check_eq(tag, acks, 0);
  endtask

  // Single fetch from idle; latency counted in cycles after the capture edge
  task automatic do_fetch(input string tag, input logic [31:0] a, input logic [31:0] exp_word,
                          input logic exp_err, input int exp_lat);
    int lat;
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = a;
    @(negedge clk);
    fetch_req = 1'b0;
    lat = 1;
    while (!fetch_ack && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_data"}, inst_Din, exp_word);
    check_eq({tag, "_err"}, {31'd0, fetch_err}, {31'd0, exp_err});
    check_eq({tag, "_busy_ack"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq({tag, "_ack_drop"}, {31'd0, fetch_ack}, 32'd0);
    check_eq({tag, "_err_drop"}, {31'd0, fetch_err}, 32'd0);
    check_eq({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] words [3];
    words[0] = 32'hA000_0001;
    words[1] = 32'hA000_0002;
    words[2] = 32'hA000_0003;

    // 1. reset then idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ack", {31'd0, fetch_ack}, 32'd0);
    check_eq("rst_err", {31'd0, fetch_err}, 32'd0);
    check_eq("rst_din", inst_Din, 32'h0);
    expect_quiet("idle_no_ack", 10);

    // 2. normal fetch, WAIT_CYCLES=2
    load_word(8'd3, 32'h0297_FD90);
    do_fetch("f0c", 32'h0000_000C, 32'h0297_FD90, 1'b0, 3);
    repeat (3) @(negedge clk);
    check_eq("din_hold", inst_Din, 32'h0297_FD90);

    // 3. error responses
    do_fetch("misalign", 32'h0000_0006, 32'h0, 1'b1, 1);
    do_fetch("range", 32'h0000_0400, 32'h0, 1'b1, 1);

    // 4. back-to-back with request held high
    for (int i = 0; i < 3; i++) load_word(ADDR_W'(i), words[i]);
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!fetch_ack && n < 12);
      check_eq($sformatf("b2b%0d_gap", i), n, 3);
      check_eq($sformatf("b2b%0d_data", i), inst_Din, words[i]);
      if (i < 2) fetch_addr = 32'(4 * (i + 1));
      else fetch_req = 1'b0;
    end
    @(negedge clk);
    check_eq("b2b_idle_busy", {31'd0, busy}, 32'd0);

    // req pulse while busy is ignored
    fetch_req = 1'b1; fetch_addr = 32'h4;
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h8;  // lands in WAIT
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    check_eq("pulse_ack", {31'd0, fetch_ack}, 32'd1);
    check_eq("pulse_data", inst_Din, words[1]);
    expect_quiet("pulse_no_extra", 8);

    // 5. read/write collision on the RESP-entry edge
    load_word(8'd5, 32'h1111_1111);
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h14;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    load_en = 1'b1; load_addr = 8'd5; load_data = 32'h2222_2222;
    @(negedge clk);
    load_en = 1'b0;
    check_eq("coll_ack", {31'd0, fetch_ack}, 32'd1);
    check_eq("coll_old", inst_Din, 32'h1111_1111);
    do_fetch("coll_new", 32'h0000_0014, 32'h2222_2222, 1'b0, 3);

    // 6. reset during WAIT aborts the fetch
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h4;
    @(negedge clk);
    fetch_req = 1'b0;
    check_eq("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_din", inst_Din, 32'h0);
    rst = 1'b0;
    expect_quiet("abort_no_ack", 6);
    do_fetch("post_rst", 32'h0000_000C, 32'h0297_FD90, 1'b0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
